// File: rtl/urv_ifetch_line_buffer.sv
// Single-line instruction buffer for the uRV fetch port. A miss refills the
// whole line, word 0 first, over a read-only Wishbone classic master.
module urv_ifetch_line_buffer #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic        inv_i,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int OFS   = $clog2(LINE_WORDS);
  localparam int TAG_W = 32 - OFS - 2;
  localparam logic [OFS-1:0] CNT_LAST = OFS'(LINE_WORDS - 1);
  localparam logic [OFS-1:0] CNT_ONE  = OFS'(1'b1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      line_q [LINE_WORDS];
  logic [31:0]      line_d [LINE_WORDS];
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
  logic             line_valid_q, line_valid_d;
  logic [OFS-1:0]   cnt_q, cnt_d;
  logic             inv_pend_q, inv_pend_d;
  logic [31:0]      im_data_q, im_data_d;
  logic             im_valid_q, im_valid_d;
  logic [31:0]      wb_adr_q, wb_adr_d;
  logic             wb_cyc_q, wb_cyc_d;

  logic [TAG_W-1:0] addr_tag_s;
  logic [OFS-1:0]   word_idx_s;
  logic             hit_s;
  logic             addr_lsb_unused_s;

  assign addr_tag_s        = im_addr_i[31:OFS+2];
  assign word_idx_s        = im_addr_i[OFS+1:2];
  assign hit_s             = line_valid_q && !inv_i && (tag_q == addr_tag_s);
  assign addr_lsb_unused_s = ^im_addr_i[1:0];

  // Next-state logic for lookup, refill sequencing and invalidation.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    tag_d        = tag_q;
    fill_tag_d   = fill_tag_q;
    line_valid_d = line_valid_q;
    cnt_d        = cnt_q;
    inv_pend_d   = inv_pend_q;
    im_data_d    = im_data_q;
    im_valid_d   = im_valid_q;
    wb_adr_d     = wb_adr_q;
    wb_cyc_d     = wb_cyc_q;
    case (state_q)
      IDLE: begin
        if (inv_i) begin
          line_valid_d = 1'b0;
        end else begin
          line_valid_d = line_valid_q;
        end
        if (hit_s) begin
          im_valid_d = 1'b1;
          im_data_d  = line_q[word_idx_s];
        end else begin
          im_valid_d = 1'b0;
          fill_tag_d = addr_tag_s;
          cnt_d      = {OFS{1'b0}};
          wb_cyc_d   = 1'b1;
          wb_adr_d   = {addr_tag_s, {(OFS+2){1'b0}}};
          state_d    = FILL;
        end
      end
      FILL: begin
        im_valid_d = 1'b0;
        if (inv_i) begin
          inv_pend_d = 1'b1;
        end else begin
          inv_pend_d = inv_pend_q;
        end
        if (wb_ack_i) begin
          line_d[cnt_q] = wb_dat_i;
          cnt_d         = cnt_q + CNT_ONE;
          wb_adr_d      = wb_adr_q + 32'd4;
          // Last word: publish the line unless an invalidate hit any part of the fill.
          if (cnt_q == CNT_LAST) begin
            wb_cyc_d     = 1'b0;
            tag_d        = fill_tag_q;
            line_valid_d = !inv_pend_q && !inv_i;
            inv_pend_d   = 1'b0;
            state_d      = IDLE;
          end else begin
            wb_cyc_d = 1'b1;
          end
        end else begin
          wb_cyc_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        wb_cyc_d   = 1'b0;
        im_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= 32'h0;
      end
      tag_q        <= {TAG_W{1'b0}};
      fill_tag_q   <= {TAG_W{1'b0}};
      line_valid_q <= 1'b0;
      cnt_q        <= {OFS{1'b0}};
      inv_pend_q   <= 1'b0;
      im_data_q    <= 32'h0;
      im_valid_q   <= 1'b0;
      wb_adr_q     <= 32'h0;
      wb_cyc_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      tag_q        <= tag_d;
      fill_tag_q   <= fill_tag_d;
      line_valid_q <= line_valid_d;
      cnt_q        <= cnt_d;
      inv_pend_q   <= inv_pend_d;
      im_data_q    <= im_data_d;
      im_valid_q   <= im_valid_d;
      wb_adr_q     <= wb_adr_d;
      wb_cyc_q     <= wb_cyc_d;
    end
  end

  assign im_data_o  = im_data_q;
  assign im_valid_o = im_valid_q;
  assign wb_adr_o   = wb_adr_q;
  assign wb_cyc_o   = wb_cyc_q;
  assign wb_stb_o   = wb_cyc_q;
  assign wb_we_o    = 1'b0;
  assign wb_sel_o   = 4'hF;

endmodule

// File: tb/tb_urv_ifetch_line_buffer.sv
// Bench for urv_ifetch_line_buffer: directed scenarios plus random fetches,
// checked against a one-line cache model with a fixed-latency miss rule.
module tb_urv_ifetch_line_buffer;

  localparam int LW         = 4;
  localparam int LINE_BYTES = LW * 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] im_addr_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic        inv_i;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int vectors     = 0;
  int miscompares = 0;
  int bus_waits   = 0;
  int wcnt        = 0;
  int cyc_cnt     = 0;
  logic [31:0] ack_q [$];

  bit          m_valid;
  logic [31:0] m_base;

  always #5 clk_i = ~clk_i;

  urv_ifetch_line_buffer #(.LINE_WORDS(LW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .im_addr_i  (im_addr_i),
    .im_data_o  (im_data_o),
    .im_valid_o (im_valid_o),
    .inv_i      (inv_i),
    .wb_adr_o   (wb_adr_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A50000;
  endfunction

  // Bus slave with a programmable number of wait states per word.
  always_comb wb_ack_i = wb_cyc_o && (wcnt == bus_waits);
  always_comb wb_dat_i = mem_word(wb_adr_o);

  always @(posedge clk_i) begin
    if (wb_cyc_o && !wb_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (wb_cyc_o && !rst_i) cyc_cnt <= cyc_cnt + 1;
    if (wb_cyc_o && wb_ack_i && !rst_i) ack_q.push_back(wb_adr_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_acks(input int start, input logic [31:0] base);
    for (int i = 0; i < LW; i++) begin
      chk("fill_adr", (start + i < ack_q.size()) ? ack_q[start + i] : 32'hFFFF_FFFF,
          base + 32'(4 * i));
    end
  endtask

  // Holds the address for lat cycles; valid must appear exactly on the last one.
  task automatic expect_after(input int lat, input logic [31:0] a, input string tag);
    int early = 0;
    for (int i = 1; i < lat; i++) begin
      step();
      inv_i = 1'b0;
      if (im_valid_o !== 1'b0) early++;
    end
    step();
    chk({tag, "_early_valid"}, 32'(early), 32'd0);
    chk({tag, "_valid"}, {31'd0, im_valid_o}, 32'd1);
    chk({tag, "_data"}, im_data_o, mem_word(a));
  endtask

  task automatic fetch(input logic [31:0] a, input int waits, input bit inv);
    logic [31:0] base;
    bit hit;
    int a0;
    int c0;
    base      = a & ~32'(LINE_BYTES - 1);
    hit       = !inv && m_valid && (m_base == base);
    bus_waits = waits;
    im_addr_i = a;
    inv_i     = inv;
    if (hit) begin
      step();
      inv_i = 1'b0;
      chk("hit_valid", {31'd0, im_valid_o}, 32'd1);
      chk("hit_data", im_data_o, mem_word(a));
      chk("hit_cyc", {31'd0, wb_cyc_o}, 32'd0);
    end else begin
      a0 = ack_q.size();
      c0 = cyc_cnt;
      expect_after(LW * (waits + 1) + 2, a, "miss");
      chk("miss_cyc_cycles", 32'(cyc_cnt - c0), 32'(LW * (waits + 1)));
      chk("miss_ack_count", 32'(ack_q.size() - a0), 32'(LW));
      check_acks(a0, base);
      m_valid = 1'b1;
      m_base  = base;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic [31:0] ra;
    rst_i     = 1'b1;
    inv_i     = 1'b0;
    im_addr_i = 32'h0;
    m_valid   = 1'b0;
    m_base    = 32'h0;
    step();
    step();
    chk("rst_valid", {31'd0, im_valid_o}, 32'd0);
    chk("rst_data", im_data_o, 32'h0);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("we_const", {31'd0, wb_we_o}, 32'd0);
    chk("sel_const", {28'd0, wb_sel_o}, 32'hF);
    rst_i = 1'b0;

    // Cold miss, then back-to-back hits on the filled line.
    fetch(32'h100, 0, 1'b0);
    fetch(32'h104, 0, 1'b0);
    fetch(32'h108, 0, 1'b0);
    fetch(32'h10C, 0, 1'b0);
    fetch(32'h100, 0, 1'b0);

    // Two wait states per word: 12 bus cycles, valid after 14.
    fetch(32'h200, 2, 1'b0);

    // Branch during a fill: the old line completes before the new lookup.
    bus_waits = 0;
    a0        = ack_q.size();
    im_addr_i = 32'h300;
    step();
    chk("branch_stb", {31'd0, wb_stb_o}, 32'd1);
    step();
    im_addr_i = 32'h400;
    expect_after(2 * LW + 1, 32'h400, "branch");
    chk("branch_ack_count", 32'(ack_q.size() - a0), 32'(2 * LW));
    check_acks(a0, 32'h300);
    check_acks(a0 + LW, 32'h400);
    m_valid = 1'b1;
    m_base  = 32'h400;
    fetch(32'h404, 0, 1'b0);

    // Invalidate mid-fill discards the line, forcing a second fill.
    a0        = ack_q.size();
    im_addr_i = 32'h500;
    step();
    inv_i = 1'b1;
    step();
    inv_i = 1'b0;
    expect_after(2 * LW + 1, 32'h500, "inv_fill");
    chk("inv_fill_ack_count", 32'(ack_q.size() - a0), 32'(2 * LW));
    check_acks(a0, 32'h500);
    check_acks(a0 + LW, 32'h500);
    m_valid = 1'b1;
    m_base  = 32'h500;
    fetch(32'h508, 0, 1'b0);
    // Invalidate in IDLE on a hitting address turns it into a miss.
    fetch(32'h504, 0, 1'b1);

    // Reset after two acks drops the fill; refill restarts at word 0.
    bus_waits = 0;
    a0        = ack_q.size();
    im_addr_i = 32'h600;
    step();
    step();
    step();
    chk("pre_rst_acks", 32'(ack_q.size() - a0), 32'd2);
    chk("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("midrst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("midrst_valid", {31'd0, im_valid_o}, 32'd0);
    chk("midrst_adr", wb_adr_o, 32'h0);
    m_valid = 1'b0;
    fetch(32'h600, 0, 1'b0);

    // Random fetches over four lines with random wait states and invalidates.
    for (int n = 0; n < 60; n++) begin
      ra = 32'h1000 + 32'($urandom_range(0, 3) * LINE_BYTES) + 32'($urandom_range(0, LW - 1) * 4);
      fetch(ra, int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/urv_ifetch_line_buffer.md
# urv_ifetch_line_buffer

Instruction-memory responder for the uRV fetch stage. Serves the fetch unit's `im_addr`/`im_data`/`im_valid` port from a single LINE_WORDS-word line buffer. Refills that buffer on a miss through a Wishbone classic read-only master port. Sits between the core's instruction port and the system bus, in place of a zero-wait instruction RAM.

## Interface
Parameters:
- LINE_WORDS, 4: words per line; power of 2, minimum 2. OFS = log2(LINE_WORDS).

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- im_addr_i  in  32  fetch address; byte address, bits [1:0] ignored.
- im_data_o  out  32  instruction word for the address presented one cycle earlier.
- im_valid_o  out  1  im_data_o is valid for the address presented one cycle earlier.
- inv_i  in  1  invalidate line (fence.i); single-cycle pulse or level.
- wb_adr_o  out  32  bus word address, byte-addressed, bits [1:0] = 0.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe; equals wb_cyc_o.
- wb_we_o  out  1  constant 0.
- wb_sel_o  out  4  constant 4'hF.
- wb_dat_i  in  32  bus read data.
- wb_ack_i  in  1  bus acknowledge; may be asserted in the same cycle as stb (zero wait).

## Operation
- State: `line[LINE_WORDS]` (32 b each), `tag` (addr[31:OFS+2]), `line_valid`, `fill_tag`, `cnt` (OFS bits), `inv_pend`, FSM {IDLE, FILL}.
- hit = line_valid && !inv_i && tag == im_addr_i[31:OFS+2].
- IDLE, hit:
  - im_valid_o <= 1.
  - im_data_o <= line[im_addr_i[OFS+1:2]].
  - Stay in IDLE.
- IDLE, miss:
  - im_valid_o <= 0.
  - fill_tag <= im_addr_i[31:OFS+2], cnt <= 0.
  - wb_cyc_o/stb_o <= 1, wb_adr_o <= {im_addr_i[31:OFS+2], 0}.
  - -> FILL.
- FILL:
  - im_valid_o held 0; im_addr_i ignored.
  - On wb_ack_i: line[cnt] <= wb_dat_i, cnt++, wb_adr_o advances by 4.
  - On the ack with cnt == LINE_WORDS-1:
    - cyc/stb <= 0, tag <= fill_tag.
    - line_valid <= !inv_pend && !inv_i; inv_pend <= 0.
    - -> IDLE.
- Fills are never aborted. A fetch-side address change (branch) during FILL is served only after the fill completes: the first IDLE cycle looks up whatever address is presented then.
- Invalidate:
  - inv_i in IDLE clears line_valid at the next edge.
  - inv_i in FILL sets inv_pend, so the completed line is discarded.
- Words are filled in ascending order from word 0; no critical-word-first.
- line_valid is set only after a complete line; no partial hits.
- im_data_o holds its last value whenever im_valid_o = 0.

## Timing
- Reset values, at the first edge with rst_i = 1, regardless of state:
  - im_valid_o = 0, im_data_o = 0.
  - wb_cyc_o = wb_stb_o = 0, wb_adr_o = 0.
  - line_valid = 0, inv_pend = 0, cnt = 0, state IDLE.
  - A bus cycle in flight is dropped; an ack arriving after reset is ignored.
- Hit latency: address in cycle N, im_valid_o/im_data_o in cycle N+1. Back-to-back hits sustain 1 word/cycle.
- Miss latency, zero-wait bus:
  - Miss seen in cycle N; cyc asserted in N+1..N+LINE_WORDS.
  - IDLE lookup in cycle N+LINE_WORDS+1; im_valid_o in cycle N+LINE_WORDS+2.
  - With LINE_WORDS = 4: data valid 6 cycles after the miss address.
- Each bus wait state adds one cycle per word.
- im_valid_o is always 0 in the cycle following any cycle spent in FILL or with rst_i high.
- Fetch-side contract: while im_valid_o = 0 the fetch re-presents the same address. The block does not rely on this; it always looks up the current im_addr_i.

## Test plan
- Reset, then im_addr_i = 0x100 with bus memory word[a] = a ^ 0xA5A50000 -> wb_adr_o steps 0x100, 0x104, 0x108, 0x10C; im_valid_o = 1 with im_data_o = 0xA5A50100 exactly 6 cycles after the address.
- After that fill, present 0x104, 0x108, 0x10C, 0x100 on consecutive cycles -> im_valid_o = 1 each following cycle with the matching data; wb_cyc_o stays 0.
- Fill at 0x200 with 2 wait states per word -> 12 bus cycles; im_valid_o stays 0 throughout; valid 14 cycles after the miss.
- Miss at 0x300, then switch im_addr_i to 0x400 mid-fill -> 0x300 line completes; the next IDLE lookup misses on 0x400 and a new fill starts at 0x400; data for 0x400 delivered.
- Pulse inv_i during a fill of 0x500 -> after the fill, re-present 0x500 -> miss and refill; inv_i in IDLE with a hitting address -> im_valid_o = 0 the next cycle.
- Assert rst_i mid-fill after 2 acks -> wb_cyc_o = 0 and im_valid_o = 0 the next cycle; the following request for the same address refills from word 0.
